// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned MAX_ADDR_W = 64;

    function automatic int unsigned offset_w(input int unsigned words);
        return $unsigned($clog2(words));
    endfunction

    function automatic int unsigned index_w(input int unsigned lines);
        return $unsigned($clog2(lines));
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines,
                                          input int unsigned words);
        return addr_w - BYTE_OFF_W - offset_w(words) - index_w(lines);
    endfunction

    // Address fields are extracted from a zero-extended address so one helper serves every ADDR_W.
    function automatic int unsigned get_offset(input logic [MAX_ADDR_W-1:0] addr,
                                               input int unsigned words);
        return 32'((addr >> BYTE_OFF_W) & MAX_ADDR_W'(words - 1));
    endfunction

    function automatic int unsigned get_index(input logic [MAX_ADDR_W-1:0] addr,
                                              input int unsigned lines, input int unsigned words);
        return 32'((addr >> (BYTE_OFF_W + offset_w(words))) & MAX_ADDR_W'(lines - 1));
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] get_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                      input int unsigned lines,
                                                      input int unsigned words);
        return addr >> (BYTE_OFF_W + offset_w(words) + index_w(lines));
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays: one combinational lookup port, a word write port, a tag/valid write port.
module dcache_store
    import dcache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4,
    parameter int unsigned TAG_W = 26,
    parameter int unsigned IDX_W = index_w(LINES),
    parameter int unsigned OFF_W = offset_w(WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inv_i,
    input  logic [IDX_W-1:0]  lk_index_i,
    input  logic [OFF_W-1:0]  lk_offset_i,
    input  logic [TAG_W-1:0]  lk_tag_i,
    output logic              lk_hit_c,
    output logic [WORD_W-1:0] lk_word_c,
    input  logic              word_we_i,
    input  logic [IDX_W-1:0]  word_index_i,
    input  logic [OFF_W-1:0]  word_offset_i,
    input  logic [WORD_W-1:0] word_data_i,
    input  logic              line_we_i,
    input  logic [IDX_W-1:0]  line_index_i,
    input  logic [TAG_W-1:0]  line_tag_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES][WORDS];

    // Valid bits are the only reset state; reset and invalidate both clear every line.
    always_ff @(posedge clk_i) begin
        if (rst_i || inv_i) begin
            valid_q <= '0;
        end else if (line_we_i) begin
            valid_q[line_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[line_index_i] <= line_tag_i;
        end
        if (word_we_i) begin
            data_q[word_index_i][word_offset_i] <= word_data_i;
        end
    end

    assign lk_hit_c  = valid_q[lk_index_i] && (tag_q[lk_index_i] == lk_tag_i);
    assign lk_word_c = data_q[lk_index_i][lk_offset_i];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack memory port.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINES  = 16,
    parameter int unsigned WORDS  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inv_i,
    input  logic              x_dm_ren_i,
    input  logic              x_dm_wen_i,
    input  logic [ADDR_W-1:0] x_dm_addr_i,
    input  logic [WORD_W-1:0] x_dm_din_i,
    output logic [WORD_W-1:0] m_dm_dout_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int unsigned OFF_W = offset_w(WORDS);
    localparam int unsigned IDX_W = index_w(LINES);
    localparam int unsigned TAG_W = tag_w(ADDR_W, LINES, WORDS);

    logic [MAX_ADDR_W-1:0] addr_ext;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_index;
    logic [OFF_W-1:0]      req_offset;

    assign addr_ext   = MAX_ADDR_W'(x_dm_addr_i);
    assign req_tag    = TAG_W'(get_tag(addr_ext, LINES, WORDS));
    assign req_index  = IDX_W'(get_index(addr_ext, LINES, WORDS));
    assign req_offset = OFF_W'(get_offset(addr_ext, WORDS));

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [WORD_W-1:0] dout_q, dout_d;

    logic              hit_c;
    logic [WORD_W-1:0] hit_word_c;
    logic              inv_all;
    logic              word_we;
    logic [OFF_W-1:0]  word_offset;
    logic [WORD_W-1:0] word_data;
    logic              line_we;

    dcache_store #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W),
        .OFF_W (OFF_W)
    ) u_store (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inv_i         (inv_all),
        .lk_index_i    (req_index),
        .lk_offset_i   (req_offset),
        .lk_tag_i      (req_tag),
        .lk_hit_c      (hit_c),
        .lk_word_c     (hit_word_c),
        .word_we_i     (word_we),
        .word_index_i  (req_index),
        .word_offset_i (word_offset),
        .word_data_i   (word_data),
        .line_we_i     (line_we),
        .line_index_i  (req_index),
        .line_tag_i    (req_tag)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            dout_q  <= dout_d;
        end
    end

    // The request is not latched: the core holds x_dm_* stable while stalled.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        dout_d      = dout_q;
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        inv_all     = 1'b0;
        word_we     = 1'b0;
        word_offset = req_offset;
        word_data   = x_dm_din_i;
        line_we     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (inv_i) begin
                    inv_all = 1'b1;
                    stall_o = 1'b1;
                end else if (x_dm_wen_i) begin
                    stall_o = 1'b1;
                    state_d = ST_WRITE;
                end else if (x_dm_ren_i) begin
                    if (hit_c) begin
                        dout_d = hit_word_c;
                    end else begin
                        stall_o = 1'b1;
                        beat_d  = '0;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {req_tag, req_index, beat_q, 2'b00};
                word_offset = beat_q;
                word_data   = mem_rdata_i;
                if (mem_ack_i) begin
                    word_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == OFF_W'(WORDS - 1)) begin
                        line_we = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {x_dm_addr_i[ADDR_W-1:2], 2'b00};
                mem_wdata_o = x_dm_din_i;
                if (mem_ack_i) begin
                    word_we = hit_c;
                    stall_o = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_dm_dout_o = dout_q;

endmodule

// File: tb/tb_dcache_dm.sv
// Randomized bench for dcache_dm against a memory image plus a line-presence model.
module tb_dcache_dm;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINES  = 16;
    localparam int unsigned WORDS  = 4;
    localparam int          BOUND  = 200;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        inv_i = 1'b0;
    logic        x_dm_ren_i = 1'b0;
    logic        x_dm_wen_i = 1'b0;
    logic [31:0] x_dm_addr_i = '0;
    logic [31:0] x_dm_din_i = '0;
    logic [31:0] m_dm_dout_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;

    dcache_dm #(
        .ADDR_W (ADDR_W),
        .LINES  (LINES),
        .WORDS  (WORDS)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inv_i       (inv_i),
        .x_dm_ren_i  (x_dm_ren_i),
        .x_dm_wen_i  (x_dm_wen_i),
        .x_dm_addr_i (x_dm_addr_i),
        .x_dm_din_i  (x_dm_din_i),
        .m_dm_dout_o (m_dm_dout_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] wmem [int unsigned];
    txn_t        txn_q [$];
    int          wait_cnt = 0;
    bit          mv   [LINES];
    int unsigned mtag [LINES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Unwritten memory reads back its own byte address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return a;
    endfunction

    task automatic mem_respond();
        txn_t t;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        if (mem_req_o) begin
            if (wait_cnt == 0) begin
                mem_ack_i = 1'b1;
                t.we   = mem_we_o;
                t.addr = mem_addr_o;
                t.data = mem_we_o ? mem_wdata_o : mem_val(mem_addr_o);
                if (mem_we_o) wmem[mem_addr_o] = mem_wdata_o;
                else          mem_rdata_i = t.data;
                txn_q.push_back(t);
                wait_cnt = int'($urandom_range(0, 2));
            end else begin
                wait_cnt--;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        mem_respond();
        #1;
    endtask

    function automatic int unsigned line_of(input logic [31:0] a);
        return (a >> 4) & (LINES - 1);
    endfunction

    task automatic do_read(input logic [31:0] addr, output bit was_hit);
        int          n = 0;
        int unsigned idx = line_of(addr);
        bit          exp_hit = mv[idx] && (mtag[idx] == (addr >> 8));
        txn_q.delete();
        x_dm_addr_i = addr;
        x_dm_ren_i  = 1'b1;
        #1;
        while (stall_o && n < BOUND) begin
            tick();
            n++;
        end
        was_hit = (n == 0);
        if (n >= BOUND) check("rd_timeout", 32'(n), 32'(0));
        check("rd_hit", 32'(was_hit), 32'(exp_hit));
        if (!was_hit) begin
            check("fill_beats", 32'(txn_q.size()), 32'(WORDS));
            for (int i = 0; i < txn_q.size() && i < int'(WORDS); i++) begin
                check("fill_addr", txn_q[i].addr, (addr & ~32'hF) + 32'(4 * i));
                check("fill_we", 32'(txn_q[i].we), 32'(0));
            end
            mv[idx]   = 1'b1;
            mtag[idx] = addr >> 8;
        end else begin
            check("hit_no_mem", 32'(txn_q.size()), 32'(0));
        end
        @(posedge clk_i);
        #1;
        check("rd_data", m_dm_dout_o, mem_val(addr & ~32'h3));
        x_dm_ren_i = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        txn_q.delete();
        x_dm_addr_i = addr;
        x_dm_din_i  = data;
        x_dm_wen_i  = 1'b1;
        #1;
        check("wr_stall", 32'(stall_o), 32'(1));
        while (stall_o && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) check("wr_timeout", 32'(n), 32'(0));
        @(posedge clk_i);
        #1;
        x_dm_wen_i = 1'b0;
        check("wr_count", 32'(txn_q.size()), 32'(1));
        if (txn_q.size() > 0) begin
            check("wr_we", 32'(txn_q[0].we), 32'(1));
            check("wr_addr", txn_q[0].addr, addr & ~32'h3);
            check("wr_data", txn_q[0].data, data);
        end
        tick();
    endtask

    task automatic do_inv();
        inv_i = 1'b1;
        #1;
        check("inv_stall", 32'(stall_o), 32'(1));
        @(posedge clk_i);
        #1;
        inv_i = 1'b0;
        #1;
        check("inv_release", 32'(stall_o), 32'(0));
        for (int i = 0; i < int'(LINES); i++) mv[i] = 1'b0;
        tick();
    endtask

    initial begin
        bit h;
        int n;
        for (int i = 0; i < int'(LINES); i++) begin
            mv[i]   = 1'b0;
            mtag[i] = 0;
        end
        repeat (3) tick();
        rst_i = 1'b0;
        #1;
        check("rst_dout", m_dm_dout_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'(0));
        check("rst_req", 32'(mem_req_o), 32'(0));

        // Cold miss then hit in the same line.
        do_read(32'h40, h);  check("t1_miss", 32'(h), 32'(0));
        do_read(32'h48, h);  check("t1_hit", 32'(h), 32'(1));
        // Conflict on index 4.
        do_read(32'h140, h); check("t2_conflict", 32'(h), 32'(0));
        do_read(32'h40, h);  check("t2_evicted", 32'(h), 32'(0));
        // Write hit updates the cached word.
        do_write(32'h44, 32'hDEAD);
        do_read(32'h44, h);  check("t3_hit", 32'(h), 32'(1));
        check("t3_data", m_dm_dout_o, 32'hDEAD);
        // Write miss does not allocate.
        do_write(32'h200, 32'h1234_5678);
        do_read(32'h200, h); check("t4_noalloc", 32'(h), 32'(0));
        // Invalidate.
        do_read(32'h40, h);
        do_inv();
        do_read(32'h40, h);  check("t5_inv_miss", 32'(h), 32'(0));

        // Reset during the third beat of a fill.
        txn_q.delete();
        x_dm_addr_i = 32'h80;
        x_dm_ren_i  = 1'b1;
        n = 0;
        #1;
        while (!(mem_req_o && !mem_we_o && mem_addr_o == 32'h88) && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) check("t6_timeout", 32'(n), 32'(0));
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        x_dm_ren_i = 1'b0;
        #1;
        check("t6_req", 32'(mem_req_o), 32'(0));
        check("t6_dout", m_dm_dout_o, 32'h0);
        for (int i = 0; i < int'(LINES); i++) mv[i] = 1'b0;
        tick();
        do_read(32'h80, h);  check("t6_refill", 32'(h), 32'(0));

        // Random mix over a small address window so lines conflict and hit often.
        for (int k = 0; k < 250; k++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [31:0] a = 32'($urandom_range(0, 255)) << 2;
            if (r == 0)      do_inv();
            else if (r <= 3) do_write(a, $urandom);
            else             do_read(a, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
